// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage.
//   - Load type codes presented by MEM with each load.
//   - Writeback FSM state encoding.
package mycpu_defs;

  localparam logic [2:0] LOAD_LW  = 3'd0;
  localparam logic [2:0] LOAD_LB  = 3'd1;
  localparam logic [2:0] LOAD_LBU = 3'd2;
  localparam logic [2:0] LOAD_LH  = 3'd3;
  localparam logic [2:0] LOAD_LHU = 3'd4;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of the writeback stage's handshake, data-bus and result signals.
//   slave  : the writeback stage's view (MEM inputs, bus read data in; RF/debug out)
//   master : the surrounding pipeline's view
interface wb_stage_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5
);

  // MEM -> WB handshake and instruction fields
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_pc;
  logic               in_wen;
  logic [RADDR_W-1:0] in_waddr;
  logic [DATA_W-1:0]  in_alu_result;
  logic               in_is_load;
  logic [2:0]         in_load_type;
  logic [1:0]         in_addr_lo;

  // Data-bus read return
  logic               data_ok;
  logic [DATA_W-1:0]  rdata;

  // Register-file write port and hazard info
  logic               rf_wen;
  logic [RADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic               load_pending;
  logic [RADDR_W-1:0] load_waddr;

  // SoC debug trace
  logic [31:0]        debug_wb_pc;
  logic [3:0]         debug_wb_rf_wen;
  logic [RADDR_W-1:0] debug_wb_rf_wnum;
  logic [DATA_W-1:0]  debug_wb_rf_wdata;

  modport slave (
    input  in_valid, in_pc, in_wen, in_waddr, in_alu_result, in_is_load, in_load_type,
           in_addr_lo, data_ok, rdata,
    output in_ready, rf_wen, rf_waddr, rf_wdata, load_pending, load_waddr, debug_wb_pc,
           debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport master (
    output in_valid, in_pc, in_wen, in_waddr, in_alu_result, in_is_load, in_load_type,
           in_addr_lo, data_ok, rdata,
    input  in_ready, rf_wen, rf_waddr, rf_wdata, load_pending, load_waddr, debug_wb_pc,
           debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

endinterface

// File: rtl/wb_stage_load_ext.sv
// Load data extraction: selects the byte/halfword lane addressed by addr_lo and
// sign- or zero-extends it according to load_type. Purely combinational.
//   rdata     in  32  raw bus read data
//   load_type in  3   LOAD_* code
//   addr_lo   in  2   byte offset of the load address
//   ext_data  out 32  value to write to the register file
module load_ext
  import mycpu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  load_type,
  input  logic [1:0]  addr_lo,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // addr_lo[0] is ignored for halfwords; misaligned accesses never reach here.
  assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
  assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ext_data = rdata;
    case (load_type)
      LOAD_LB:  ext_data = {{24{byte_lane[7]}}, byte_lane};
      LOAD_LBU: ext_data = {24'h0, byte_lane};
      LOAD_LH:  ext_data = {{16{half_lane[15]}}, half_lane};
      LOAD_LHU: ext_data = {16'h0, half_lane};
      default:  ext_data = rdata;  // LW and undefined codes pass through
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage of the 5-stage MIPS pipeline.
// Retires one instruction per MEM handshake. Non-loads write their ALU result the
// next cycle; loads are parked in WAIT until data_ok returns the read data, which is
// then extended and written. All outputs except in_ready are registered so the
// negedge-writing register file sees stable values for the whole cycle.
//   clk    in  pipeline clock
//   resetn in  asynchronous active-low reset
//   bus    slave side of wb_stage_if (handshake, bus return, RF write, debug trace)
module wb_stage
  import mycpu_defs::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RADDR_W  = 5,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input logic       clk,
  input logic       resetn,
  wb_stage_if.slave bus
);

  wb_state_e state_q, state_d;

  // Latched fields of a load awaiting data
  logic [31:0]        ld_pc_q, ld_pc_d;
  logic [RADDR_W-1:0] ld_waddr_q, ld_waddr_d;
  logic               ld_wen_q, ld_wen_d;
  logic [2:0]         ld_type_q, ld_type_d;
  logic [1:0]         ld_addr_lo_q, ld_addr_lo_d;

  // Output registers
  logic               rf_wen_q, rf_wen_d;
  logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
  logic [31:0]        wb_pc_q, wb_pc_d;

  logic [31:0] ext_data;

  load_ext u_load_ext (
    .rdata     (bus.rdata),
    .load_type (ld_type_q),
    .addr_lo   (ld_addr_lo_q),
    .ext_data  (ext_data)
  );

  always_comb begin
    state_d      = state_q;
    ld_pc_d      = ld_pc_q;
    ld_waddr_d   = ld_waddr_q;
    ld_wen_d     = ld_wen_q;
    ld_type_d    = ld_type_q;
    ld_addr_lo_d = ld_addr_lo_q;
    rf_wen_d     = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    wb_pc_d      = wb_pc_q;

    unique case (state_q)
      StIdle: begin
        // data_ok here is stale/spurious and deliberately ignored.
        if (bus.in_valid) begin
          if (bus.in_is_load) begin
            ld_pc_d      = bus.in_pc;
            ld_waddr_d   = bus.in_waddr;
            ld_wen_d     = bus.in_wen;
            ld_type_d    = bus.in_load_type;
            ld_addr_lo_d = bus.in_addr_lo;
            state_d      = StWait;
          end else begin
            rf_wen_d   = bus.in_wen & (bus.in_waddr != '0);
            rf_waddr_d = bus.in_waddr;
            rf_wdata_d = bus.in_alu_result;
            wb_pc_d    = bus.in_pc;
          end
        end
      end
      StWait: begin
        if (bus.data_ok) begin
          rf_wen_d   = ld_wen_q & (ld_waddr_q != '0);
          rf_waddr_d = ld_waddr_q;
          rf_wdata_d = ext_data;
          wb_pc_d    = ld_pc_q;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      ld_pc_q      <= '0;
      ld_waddr_q   <= '0;
      ld_wen_q     <= 1'b0;
      ld_type_q    <= LOAD_LW;
      ld_addr_lo_q <= '0;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      wb_pc_q      <= RESET_PC;
    end else begin
      state_q      <= state_d;
      ld_pc_q      <= ld_pc_d;
      ld_waddr_q   <= ld_waddr_d;
      ld_wen_q     <= ld_wen_d;
      ld_type_q    <= ld_type_d;
      ld_addr_lo_q <= ld_addr_lo_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      wb_pc_q      <= wb_pc_d;
    end
  end

  assign bus.in_ready          = (state_q == StIdle);
  assign bus.load_pending      = (state_q == StWait);
  assign bus.load_waddr        = ld_waddr_q;
  assign bus.rf_wen            = rf_wen_q;
  assign bus.rf_waddr          = rf_waddr_q;
  assign bus.rf_wdata          = rf_wdata_q;
  assign bus.debug_wb_pc       = wb_pc_q;
  assign bus.debug_wb_rf_wen   = {4{rf_wen_q}};
  assign bus.debug_wb_rf_wnum  = rf_waddr_q;
  assign bus.debug_wb_rf_wdata = rf_wdata_q;

endmodule
